oam_access_ctrl: RTL and testbench
==================================

// Module: oam_access_ctrl
// PURPOSE
// Parametrised OAM access controller for the video pages. Arbitrates the DMA, sprite-scan, render and CPU
// requesters onto a two-bank (A = even byte, B = odd byte) sprite attribute RAM. Owns the sprite-scan
// entry counter and FSM, and registers read data for every requester.
// It succeeds the fixed 40-entry/8-bit OAM glue: entry count, entry size and data width are generalised,
// and it adds scan start/done handshakes, a CPU read-valid return path and write-through on DMA.
// PARAMETERS
// NUM_ENTRIES  40                                 number of sprite entries scanned
// ENTRY_BYTES  4                                  bytes per entry; power of 2, >= 2
// DATA_W       8                                  byte width
// ADDR_W       $clog2(NUM_ENTRIES*ENTRY_BYTES)    byte address width (derived)
// IDX_W        $clog2(NUM_ENTRIES)                entry index width (derived)
// PORTS
// clk           in   1        video clock; all state on rising edge
// reset_video   in   1        synchronous, active-high reset
// scan_start    in   1        pulse: begin scan at entry 0
// scan_step     in   1        advance scan one entry this cycle
// scan_busy     out  1        scan FSM in SCAN
// scan_done     out  1        1-cycle pulse after last entry read
// scan_idx      out  IDX_W    current scan entry
// render_en     in   1        render fetch request
// render_idx    in   IDX_W    entry to fetch for render
// dma_run       in   1        DMA owns OAM
// dma_we        in   1        DMA byte write strobe
// dma_addr      in   ADDR_W   DMA byte address
// dma_wdata     in   DATA_W   DMA write byte
// cpu_rd        in   1        CPU read strobe (1 cycle)
// cpu_wr        in   1        CPU write strobe (1 cycle)
// cpu_addr      in   ADDR_W   CPU byte address
// cpu_wdata     in   DATA_W   CPU write byte
// cpu_rdata     out  DATA_W   CPU read byte
// cpu_rvalid    out  1        cpu_rdata valid pulse
// oam_waddr     out  ADDR_W-1 word address to both banks
// oam_a_ncs     out  1        bank A select, active-low
// oam_b_ncs     out  1        bank B select, active-low
// oam_nwe       out  1        write enable, active-low
// oam_wdata     out  DATA_W   write byte (both banks)
// oam_a_rdata   in   DATA_W   bank A read data (valid 1 cycle after select)
// oam_b_rdata   in   DATA_W   bank B read data
// obj_a, obj_b  out  DATA_W   registered word read for scan/render
// obj_valid     out  1        obj_a/obj_b valid pulse
// obj_is_scan   out  1        qualifies obj_valid: 1 = scan word, 0 = render word
// BEHAVIOUR
// - Reset: scan_busy=0, scan_done=0, scan_idx=0, cpu_rvalid=0, cpu_rdata=0, obj_valid=0, obj_a=obj_b=0,
//   oam_a_ncs=oam_b_ncs=1, oam_nwe=1. An in-flight scan, render or CPU read is abandoned; no valid pulse follows.
// - Fixed grant priority per cycle: DMA (dma_run) > SCAN (scan_busy) > RENDER (render_en) > CPU. Grant is combinational.
// - Byte addr -> oam_waddr = addr>>1; bank A if addr[0]=0, else bank B.
// - Scan reads word idx*ENTRY_BYTES/2, both banks. Render reads word render_idx*ENTRY_BYTES/2+1, both banks.
// - DMA: write only. dma_we drives oam_nwe=0 and selects the addressed bank only, same cycle.
// - CPU: granted only when no higher requester is active. Write selects one bank with oam_nwe=0.
//   Read: cpu_rvalid=1 the next cycle, with the bank byte in cpu_rdata.
// - CPU blocked: write is dropped silently. Read still gives cpu_rvalid next cycle with cpu_rdata = all ones.
// - Read latency is 1 cycle, all requesters: obj_* and cpu_rdata are registered from oam_*_rdata.
// - Scan FSM: IDLE -> SCAN on scan_start. In SCAN, a word read issues every cycle.
//   scan_step increments scan_idx; obj_valid/obj_is_scan=1 one cycle after each read.
//   On scan_step at idx=NUM_ENTRIES-1: scan_idx <- 0, -> IDLE, scan_done=1 next cycle.
// - scan_start while in SCAN restarts at idx 0, with no done pulse.
// - While dma_run=1, scan_step is ignored: idx holds and no scan read issues.
// - Simultaneous cpu_rd and cpu_wr: the write wins and no rvalid is produced.
// - Addresses >= NUM_ENTRIES*ENTRY_BYTES: CPU read returns all ones; CPU and DMA writes are dropped.
// TESTING
// - Reset mid-scan at idx 17 -> next cycle scan_busy=0, scan_idx=0, no scan_done, all selects high.
// - scan_start, then 40 scan_step cycles with OAM prefilled -> obj_valid x40 with words 0,2,..,78;
//   scan_done on the cycle after step 40.
// - CPU rd 0x05 while idle (OAM[5]=0x3C) -> cpu_rvalid next cycle with 0x3C.
//   Same read during scan -> cpu_rvalid with 0xFF.
// - DMA writes 0xA5 to 0x9F while cpu_wr 0x11 to 0x9F in the same cycle -> OAM[0x9F]=0xA5.
// - dma_run held during scan at idx 10 for 8 steps -> idx stays 10 with no scan reads; resumes on release.
// - render_en idx 3, no scan/DMA -> oam_waddr=7 with both banks selected; obj_valid next cycle, obj_is_scan=0.

Source files
------------

// File: rtl/oam_access_ctrl_if.sv
// oam_access_ctrl_if: requester handshakes and two-bank OAM bus of the OAM access controller
interface oam_access_ctrl_if #(
  parameter int NUM_ENTRIES = 40,
  parameter int ENTRY_BYTES = 4,
  parameter int DATA_W = 8,
  parameter int ADDR_W = $clog2(NUM_ENTRIES * ENTRY_BYTES),
  parameter int IDX_W = $clog2(NUM_ENTRIES)
);
  logic scan_start;
  logic scan_step;
  logic scan_busy;
  logic scan_done;
  logic [IDX_W-1:0] scan_idx;
  logic render_en;
  logic [IDX_W-1:0] render_idx;
  logic dma_run;
  logic dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic cpu_rd;
  logic cpu_wr;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic cpu_rvalid;
  logic [ADDR_W-2:0] oam_waddr;
  logic oam_a_ncs;
  logic oam_b_ncs;
  logic oam_nwe;
  logic [DATA_W-1:0] oam_wdata;
  logic [DATA_W-1:0] oam_a_rdata;
  logic [DATA_W-1:0] oam_b_rdata;
  logic [DATA_W-1:0] obj_a;
  logic [DATA_W-1:0] obj_b;
  logic obj_valid;
  logic obj_is_scan;
  modport master (
    output scan_start, scan_step, render_en, render_idx, dma_run, dma_we, dma_addr, dma_wdata,
           cpu_rd, cpu_wr, cpu_addr, cpu_wdata, oam_a_rdata, oam_b_rdata,
    input  scan_busy, scan_done, scan_idx, cpu_rdata, cpu_rvalid, oam_waddr, oam_a_ncs, oam_b_ncs,
           oam_nwe, oam_wdata, obj_a, obj_b, obj_valid, obj_is_scan
  );
  modport slave (
    input  scan_start, scan_step, render_en, render_idx, dma_run, dma_we, dma_addr, dma_wdata,
           cpu_rd, cpu_wr, cpu_addr, cpu_wdata, oam_a_rdata, oam_b_rdata,
    output scan_busy, scan_done, scan_idx, cpu_rdata, cpu_rvalid, oam_waddr, oam_a_ncs, oam_b_ncs,
           oam_nwe, oam_wdata, obj_a, obj_b, obj_valid, obj_is_scan
  );
endinterface

// File: rtl/oam_access_ctrl.sv
// oam_access_ctrl: arbitrates DMA, sprite scan, render and CPU onto a two-bank sprite attribute RAM
module oam_access_ctrl #(
  parameter int NUM_ENTRIES = 40,
  parameter int ENTRY_BYTES = 4,
  parameter int DATA_W = 8
) (
  input logic clk,
  input logic reset_video,
  oam_access_ctrl_if.slave bus
);
  localparam int ADDR_W = $clog2(NUM_ENTRIES * ENTRY_BYTES);
  localparam int IDX_W = $clog2(NUM_ENTRIES);
  localparam int WA = ADDR_W - 1;
  localparam int SIZE = NUM_ENTRIES * ENTRY_BYTES;
  typedef enum logic {IDLE, SCAN} state_t;
  state_t state;
  state_t state_nx;
  logic scan_g;
  logic rend_g;
  logic cpu_g;
  logic dma_wr;
  logic cpu_req;
  logic cpu_w;
  logic cpu_r;
  logic step;
  logic last;
  logic [IDX_W-1:0] idx_nx;
  always_comb begin
    scan_g = state == SCAN && !bus.dma_run;
    rend_g = bus.render_en && !bus.dma_run && state == IDLE;
    cpu_g = !bus.dma_run && state == IDLE && !bus.render_en;
    dma_wr = bus.dma_run && bus.dma_we && 32'(bus.dma_addr) < SIZE;
    cpu_req = bus.cpu_rd && !bus.cpu_wr;
    cpu_w = cpu_g && bus.cpu_wr && 32'(bus.cpu_addr) < SIZE;
    cpu_r = cpu_g && cpu_req && 32'(bus.cpu_addr) < SIZE;
    step = scan_g && bus.scan_step;
    last = bus.scan_idx == IDX_W'(NUM_ENTRIES - 1);
    state_nx = bus.scan_start ? SCAN : (step && last) ? IDLE : state;
    idx_nx = (bus.scan_start || (step && last)) ? '0 : step ? bus.scan_idx + IDX_W'(1) : bus.scan_idx;
    bus.oam_waddr = bus.dma_run ? bus.dma_addr[ADDR_W-1:1] :
                    scan_g ? WA'(bus.scan_idx) * WA'(ENTRY_BYTES / 2) :
                    rend_g ? WA'(bus.render_idx) * WA'(ENTRY_BYTES / 2) + WA'(1) :
                    bus.cpu_addr[ADDR_W-1:1];
    bus.oam_a_ncs = !(scan_g || rend_g || (dma_wr && !bus.dma_addr[0]) || ((cpu_w || cpu_r) && !bus.cpu_addr[0]));
    bus.oam_b_ncs = !(scan_g || rend_g || (dma_wr && bus.dma_addr[0]) || ((cpu_w || cpu_r) && bus.cpu_addr[0]));
    bus.oam_nwe = !(dma_wr || cpu_w);
    bus.oam_wdata = bus.dma_run ? bus.dma_wdata : bus.cpu_wdata;
  end
  assign bus.scan_busy = state == SCAN;
  always_ff @(posedge clk) state <= reset_video ? IDLE : state_nx;
  always_ff @(posedge clk)
    if (reset_video) begin
      bus.scan_idx <= '0;
      bus.scan_done <= 1'b0;
      bus.cpu_rvalid <= 1'b0;
      bus.cpu_rdata <= '0;
      bus.obj_valid <= 1'b0;
      bus.obj_is_scan <= 1'b0;
      bus.obj_a <= '0;
      bus.obj_b <= '0;
    end else begin
      bus.scan_idx <= idx_nx;
      bus.scan_done <= step && last && !bus.scan_start;
      bus.cpu_rvalid <= cpu_req;
      if (cpu_req) bus.cpu_rdata <= !cpu_r ? '1 : bus.cpu_addr[0] ? bus.oam_b_rdata : bus.oam_a_rdata;
      bus.obj_valid <= scan_g || rend_g;
      if (scan_g || rend_g) begin
        bus.obj_is_scan <= scan_g;
        bus.obj_a <= bus.oam_a_rdata;
        bus.obj_b <= bus.oam_b_rdata;
      end
    end
endmodule

// File: tb/tb_oam_access_ctrl.sv
// tb_oam_access_ctrl: directed vector table and scan sequences for oam_access_ctrl
module tb_oam_access_ctrl;
  logic clk = 1'b0;
  logic rst;
  int tests = 0;
  int fails = 0;
  logic [7:0] mem [256];
  oam_access_ctrl_if bus();
  oam_access_ctrl dut(.clk(clk), .reset_video(rst), .bus(bus));
  always #5 clk = ~clk;
  always_comb begin
    bus.oam_a_rdata = bus.oam_a_ncs ? 8'hEE : mem[{bus.oam_waddr, 1'b0}];
    bus.oam_b_rdata = bus.oam_b_ncs ? 8'hEE : mem[{bus.oam_waddr, 1'b1}];
  end
  always @(posedge clk)
    if (!bus.oam_nwe) begin
      if (!bus.oam_a_ncs) mem[{bus.oam_waddr, 1'b0}] <= bus.oam_wdata;
      if (!bus.oam_b_ncs) mem[{bus.oam_waddr, 1'b1}] <= bus.oam_wdata;
    end
  typedef struct {
    logic rd;
    logic wr;
    logic [7:0] ca;
    logic [7:0] cd;
    logic ren;
    logic [5:0] ridx;
    logic dr;
    logic dw;
    logic [7:0] da;
    logic [7:0] dd;
    logic [6:0] waddr;
    logic ancs;
    logic bncs;
    logic nwe;
    logic rv;
    logic [7:0] rdata;
    logic ov;
    logic [7:0] oa;
    logic [7:0] ob;
  } vec_t;
  vec_t vt [16];
  function automatic logic [7:0] ef(input int a);
    return a == 5 ? 8'h3C : 8'(a * 7 + 3);
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    bus.scan_start = '0;
    bus.scan_step = '0;
    bus.render_en = '0;
    bus.render_idx = '0;
    bus.dma_run = '0;
    bus.dma_we = '0;
    bus.dma_addr = '0;
    bus.dma_wdata = '0;
    bus.cpu_rd = '0;
    bus.cpu_wr = '0;
    bus.cpu_addr = '0;
    bus.cpu_wdata = '0;
  endtask
  initial begin
    vt[0]  = '{1'b1, 1'b0, 8'h05, 8'h00, 1'b0, 6'd0,  1'b0, 1'b0, 8'h00, 8'h00, 7'd2,  1'b1, 1'b0, 1'b1, 1'b1, 8'h3C, 1'b0, 8'h00, 8'h00};
    vt[1]  = '{1'b1, 1'b0, 8'h04, 8'h00, 1'b0, 6'd0,  1'b0, 1'b0, 8'h00, 8'h00, 7'd2,  1'b0, 1'b1, 1'b1, 1'b1, 8'h1F, 1'b0, 8'h00, 8'h00};
    vt[2]  = '{1'b0, 1'b1, 8'h10, 8'h77, 1'b0, 6'd0,  1'b0, 1'b0, 8'h00, 8'h00, 7'd8,  1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00};
    vt[3]  = '{1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 6'd0,  1'b0, 1'b0, 8'h00, 8'h00, 7'd8,  1'b0, 1'b1, 1'b1, 1'b1, 8'h77, 1'b0, 8'h00, 8'h00};
    vt[4]  = '{1'b1, 1'b1, 8'h11, 8'h66, 1'b0, 6'd0,  1'b0, 1'b0, 8'h00, 8'h00, 7'd8,  1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00};
    vt[5]  = '{1'b1, 1'b0, 8'h11, 8'h00, 1'b0, 6'd0,  1'b0, 1'b0, 8'h00, 8'h00, 7'd8,  1'b1, 1'b0, 1'b1, 1'b1, 8'h66, 1'b0, 8'h00, 8'h00};
    vt[6]  = '{1'b1, 1'b0, 8'hA0, 8'h00, 1'b0, 6'd0,  1'b0, 1'b0, 8'h00, 8'h00, 7'd0,  1'b1, 1'b1, 1'b1, 1'b1, 8'hFF, 1'b0, 8'h00, 8'h00};
    vt[7]  = '{1'b0, 1'b1, 8'hA0, 8'h55, 1'b0, 6'd0,  1'b0, 1'b0, 8'h00, 8'h00, 7'd0,  1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00};
    vt[8]  = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 6'd3,  1'b0, 1'b0, 8'h00, 8'h00, 7'd7,  1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h65, 8'h6C};
    vt[9]  = '{1'b1, 1'b0, 8'h05, 8'h00, 1'b1, 6'd3,  1'b0, 1'b0, 8'h00, 8'h00, 7'd7,  1'b0, 1'b0, 1'b1, 1'b1, 8'hFF, 1'b1, 8'h65, 8'h6C};
    vt[10] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 6'd39, 1'b0, 1'b0, 8'h00, 8'h00, 7'd79, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h55, 8'h5C};
    vt[11] = '{1'b1, 1'b0, 8'h05, 8'h00, 1'b0, 6'd0,  1'b1, 1'b0, 8'h00, 8'h00, 7'd0,  1'b1, 1'b1, 1'b1, 1'b1, 8'hFF, 1'b0, 8'h00, 8'h00};
    vt[12] = '{1'b0, 1'b1, 8'h9F, 8'h11, 1'b0, 6'd0,  1'b1, 1'b1, 8'h9F, 8'hA5, 7'h4F, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00};
    vt[13] = '{1'b1, 1'b0, 8'h9F, 8'h00, 1'b0, 6'd0,  1'b0, 1'b0, 8'h00, 8'h00, 7'h4F, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 8'h00, 8'h00};
    vt[14] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 6'd0,  1'b1, 1'b1, 8'hA0, 8'h33, 7'd0,  1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00};
    vt[15] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 6'd3,  1'b1, 1'b0, 8'h00, 8'h00, 7'd0,  1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00};
    idle();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    chk("rst busy", 32'(bus.scan_busy), 32'(0));
    chk("rst done", 32'(bus.scan_done), 32'(0));
    chk("rst idx", 32'(bus.scan_idx), 32'(0));
    chk("rst rvalid", 32'(bus.cpu_rvalid), 32'(0));
    chk("rst rdata", 32'(bus.cpu_rdata), 32'(0));
    chk("rst ovalid", 32'(bus.obj_valid), 32'(0));
    chk("rst obj_a", 32'(bus.obj_a), 32'(0));
    chk("rst obj_b", 32'(bus.obj_b), 32'(0));
    chk("rst ancs", 32'(bus.oam_a_ncs), 32'(1));
    chk("rst bncs", 32'(bus.oam_b_ncs), 32'(1));
    chk("rst nwe", 32'(bus.oam_nwe), 32'(1));
    for (int i = 0; i < 160; i++) begin
      bus.dma_run = 1'b1;
      bus.dma_we = 1'b1;
      bus.dma_addr = 8'(i);
      bus.dma_wdata = ef(i);
      tick();
    end
    idle();
    tick();
    bus.scan_start = 1'b1;
    tick();
    bus.scan_start = 1'b0;
    bus.scan_step = 1'b1;
    chk("scan busy", 32'(bus.scan_busy), 32'(1));
    for (int k = 0; k < 40; k++) begin
      chk($sformatf("scan idx%0d", k), 32'(bus.scan_idx), 32'(k));
      tick();
      chk($sformatf("scan ov%0d", k), 32'(bus.obj_valid), 32'(1));
      chk($sformatf("scan is_scan%0d", k), 32'(bus.obj_is_scan), 32'(1));
      chk($sformatf("scan obj_a%0d", k), 32'(bus.obj_a), 32'(ef(4 * k)));
      chk($sformatf("scan obj_b%0d", k), 32'(bus.obj_b), 32'(ef(4 * k + 1)));
      if (k < 39) chk($sformatf("scan nodone%0d", k), 32'(bus.scan_done), 32'(0));
    end
    bus.scan_step = 1'b0;
    chk("end done", 32'(bus.scan_done), 32'(1));
    chk("end busy", 32'(bus.scan_busy), 32'(0));
    chk("end idx", 32'(bus.scan_idx), 32'(0));
    tick();
    chk("end done pulse", 32'(bus.scan_done), 32'(0));
    bus.scan_start = 1'b1;
    tick();
    bus.scan_start = 1'b0;
    bus.cpu_rd = 1'b1;
    bus.cpu_addr = 8'h05;
    tick();
    bus.cpu_rd = 1'b0;
    chk("blk rvalid", 32'(bus.cpu_rvalid), 32'(1));
    chk("blk rdata", 32'(bus.cpu_rdata), 32'hFF);
    chk("hold ov", 32'(bus.obj_valid), 32'(1));
    chk("hold idx", 32'(bus.scan_idx), 32'(0));
    bus.scan_step = 1'b1;
    repeat (10) tick();
    chk("pre dma idx", 32'(bus.scan_idx), 32'(10));
    bus.dma_run = 1'b1;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      chk($sformatf("dma ancs%0d", j), 32'(bus.oam_a_ncs), 32'(1));
      chk($sformatf("dma bncs%0d", j), 32'(bus.oam_b_ncs), 32'(1));
      tick();
      chk($sformatf("dma idx%0d", j), 32'(bus.scan_idx), 32'(10));
      chk($sformatf("dma ov%0d", j), 32'(bus.obj_valid), 32'(0));
    end
    bus.dma_run = 1'b0;
    tick();
    bus.scan_step = 1'b0;
    chk("resume idx", 32'(bus.scan_idx), 32'(11));
    chk("resume ov", 32'(bus.obj_valid), 32'(1));
    chk("resume obj_a", 32'(bus.obj_a), 32'(ef(40)));
    bus.scan_start = 1'b1;
    tick();
    bus.scan_start = 1'b0;
    chk("restart idx", 32'(bus.scan_idx), 32'(0));
    chk("restart busy", 32'(bus.scan_busy), 32'(1));
    chk("restart done", 32'(bus.scan_done), 32'(0));
    bus.scan_step = 1'b1;
    repeat (17) tick();
    chk("mid idx", 32'(bus.scan_idx), 32'(17));
    rst = 1'b1;
    bus.cpu_rd = 1'b1;
    bus.cpu_addr = 8'h05;
    tick();
    rst = 1'b0;
    idle();
    chk("mrst busy", 32'(bus.scan_busy), 32'(0));
    chk("mrst idx", 32'(bus.scan_idx), 32'(0));
    chk("mrst done", 32'(bus.scan_done), 32'(0));
    chk("mrst rvalid", 32'(bus.cpu_rvalid), 32'(0));
    chk("mrst rdata", 32'(bus.cpu_rdata), 32'(0));
    chk("mrst ov", 32'(bus.obj_valid), 32'(0));
    @(negedge clk);
    chk("mrst ancs", 32'(bus.oam_a_ncs), 32'(1));
    chk("mrst bncs", 32'(bus.oam_b_ncs), 32'(1));
    chk("mrst nwe", 32'(bus.oam_nwe), 32'(1));
    tick();
    chk("mrst done2", 32'(bus.scan_done), 32'(0));
    chk("mrst rvalid2", 32'(bus.cpu_rvalid), 32'(0));
    for (int i = 0; i < 16; i++) begin
      bus.cpu_rd = vt[i].rd;
      bus.cpu_wr = vt[i].wr;
      bus.cpu_addr = vt[i].ca;
      bus.cpu_wdata = vt[i].cd;
      bus.render_en = vt[i].ren;
      bus.render_idx = vt[i].ridx;
      bus.dma_run = vt[i].dr;
      bus.dma_we = vt[i].dw;
      bus.dma_addr = vt[i].da;
      bus.dma_wdata = vt[i].dd;
      @(negedge clk);
      chk($sformatf("v%0d ancs", i), 32'(bus.oam_a_ncs), 32'(vt[i].ancs));
      chk($sformatf("v%0d bncs", i), 32'(bus.oam_b_ncs), 32'(vt[i].bncs));
      chk($sformatf("v%0d nwe", i), 32'(bus.oam_nwe), 32'(vt[i].nwe));
      if (!vt[i].ancs || !vt[i].bncs) chk($sformatf("v%0d waddr", i), 32'(bus.oam_waddr), 32'(vt[i].waddr));
      tick();
      chk($sformatf("v%0d rvalid", i), 32'(bus.cpu_rvalid), 32'(vt[i].rv));
      if (vt[i].rv) chk($sformatf("v%0d rdata", i), 32'(bus.cpu_rdata), 32'(vt[i].rdata));
      chk($sformatf("v%0d ovalid", i), 32'(bus.obj_valid), 32'(vt[i].ov));
      if (vt[i].ov) begin
        chk($sformatf("v%0d is_scan", i), 32'(bus.obj_is_scan), 32'(0));
        chk($sformatf("v%0d obj_a", i), 32'(bus.obj_a), 32'(vt[i].oa));
        chk($sformatf("v%0d obj_b", i), 32'(bus.obj_b), 32'(vt[i].ob));
      end
      idle();
    end
    chk("mem 9F", 32'(mem[8'h9F]), 32'hA5);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
